// File: rtl/checkpoint_id_allocator_pkg.sv
// Shared types and sizing for the checkpoint ID allocator and its neighbours.
`ifndef CHECKPOINT_ID_WIDTH
`define CHECKPOINT_ID_WIDTH 6
`endif

package checkpoint_id_allocator_pkg;

  localparam int CHECKPOINT_ID_W = `CHECKPOINT_ID_WIDTH;
  localparam int CHECKPOINT_NUM  = 1 << CHECKPOINT_ID_W;

  typedef logic [`CHECKPOINT_ID_WIDTH-1:0] checkpoint_id_t;

  // Commit-stage feedback; only enable and flush matter to the allocator.
  typedef struct packed {
    logic enable;
    logic flush;
  } commit_feedback_pack_t;

endpackage

// File: rtl/checkpoint_id_allocator_free_list_fifo.sv
// Circular free list of checkpoint IDs: one pop and up to two pushes per
// cycle. Reset and init both reload the identity list (every ID free).
module free_list_fifo
  import checkpoint_id_allocator_pkg::*;
#(
  parameter int DEPTH = CHECKPOINT_NUM,
  parameter int ID_W  = CHECKPOINT_ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic            rd_en,
  input  logic            wr0_en,
  input  logic [ID_W-1:0] wr0_id,
  input  logic            wr1_en,
  input  logic [ID_W-1:0] wr1_id,
  output logic [ID_W-1:0] rd_id,
  output logic [ID_W:0]   count,
  output logic            empty,
  output logic            full
);

  localparam logic [ID_W:0] PTR_DEPTH = (ID_W+1)'(DEPTH);
  localparam logic [ID_W:0] PTR_ONE   = {{ID_W{1'b0}}, 1'b1};

  logic [ID_W-1:0] ram_r [DEPTH];
  logic [ID_W:0]   rd_ptr_r;
  logic [ID_W:0]   wr_ptr_r;
  logic [ID_W:0]   count_r;
  logic            empty_r;
  logic            full_r;

  logic [ID_W:0]   wr_ptr_inc_s;
  logic [ID_W-1:0] widx0_s;
  logic [ID_W-1:0] widx1_s;
  logic [ID_W:0]   rd_ptr_nxt_s;
  logic [ID_W:0]   wr_ptr_nxt_s;
  logic [ID_W:0]   count_nxt_s;

  // Write slots, next pointers and next occupancy; a lone second write
  // takes the slot at wr_ptr so the list stays dense.
  always_comb begin
    wr_ptr_inc_s = wr_ptr_r + PTR_ONE;
    widx0_s      = wr_ptr_r[ID_W-1:0];
    if (wr0_en) begin
      widx1_s = wr_ptr_inc_s[ID_W-1:0];
    end else begin
      widx1_s = wr_ptr_r[ID_W-1:0];
    end
    rd_ptr_nxt_s = rd_ptr_r + (ID_W+1)'(rd_en);
    wr_ptr_nxt_s = wr_ptr_r + (ID_W+1)'(wr0_en) + (ID_W+1)'(wr1_en);
    count_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
  end

  // Storage, pointers and registered status; init reloads the identity list.
  always_ff @(posedge clk) begin
    if (!rst || init) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_r[i] <= ID_W'(i);
      end
      rd_ptr_r <= {(ID_W+1){1'b0}};
      wr_ptr_r <= PTR_DEPTH;
      count_r  <= PTR_DEPTH;
      empty_r  <= 1'b0;
      full_r   <= 1'b1;
    end else begin
      if (wr0_en) begin
        ram_r[widx0_s] <= wr0_id;
      end
      if (wr1_en) begin
        ram_r[widx1_s] <= wr1_id;
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      count_r  <= count_nxt_s;
      empty_r  <= (count_nxt_s == {(ID_W+1){1'b0}});
      full_r   <= (count_nxt_s == PTR_DEPTH);
    end
  end

  assign rd_id = ram_r[rd_ptr_r[ID_W-1:0]];
  assign count = count_r;
  assign empty = empty_r;
  assign full  = full_r;

endmodule

// File: rtl/checkpoint_id_allocator.sv
// Checkpoint ID allocator: grants one free ID per cycle, reclaims IDs from
// branch resolution and commit, and returns everything on a commit flush.
module checkpoint_id_allocator
  import checkpoint_id_allocator_pkg::*;
#(
  parameter int DEPTH = CHECKPOINT_NUM,
  parameter int ID_W  = CHECKPOINT_ID_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  output logic                  alloc_grant,
  output logic [ID_W-1:0]       alloc_id,
  input  logic                  bru_free_valid,
  input  logic [ID_W-1:0]       bru_free_id,
  input  logic                  commit_free_valid,
  input  logic [ID_W-1:0]       commit_free_id,
  input  commit_feedback_pack_t commit_feedback_pack,
  output logic [ID_W:0]         free_count,
  output logic                  empty,
  output logic                  full,
  output logic                  double_free_err
);

  localparam logic [DEPTH-1:0] MASK_ZERO = {DEPTH{1'b0}};

  logic             flush_s;
  logic             grant_s;
  logic             bru_ok_s;
  logic             commit_ok_s;
  logic             err_set_s;
  logic [DEPTH-1:0] set_mask_s;
  logic [DEPTH-1:0] clr_mask_s;
  logic [DEPTH-1:0] in_use_nxt_s;

  logic [DEPTH-1:0] in_use_r;
  logic             err_r;

  logic [ID_W-1:0]  fifo_rd_id_s;
  logic [ID_W:0]    fifo_count_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;

  // Grant and free validation. Frees are checked against the bitmap as it
  // stood before this cycle's allocation; BRU wins a same-ID tie with commit.
  always_comb begin
    flush_s     = commit_feedback_pack.enable & commit_feedback_pack.flush;
    grant_s     = alloc_req & ~fifo_empty_s & ~flush_s;
    bru_ok_s    = 1'b0;
    commit_ok_s = 1'b0;
    err_set_s   = 1'b0;
    if (flush_s) begin
      bru_ok_s    = 1'b0;
      commit_ok_s = 1'b0;
      err_set_s   = 1'b0;
    end else begin
      bru_ok_s    = bru_free_valid & in_use_r[bru_free_id];
      commit_ok_s = commit_free_valid & in_use_r[commit_free_id]
                    & ~(bru_ok_s & (bru_free_id == commit_free_id));
      err_set_s   = (bru_free_valid & ~bru_ok_s)
                    | (commit_free_valid & ~commit_ok_s);
    end
    set_mask_s   = {{(DEPTH-1){1'b0}}, grant_s} << fifo_rd_id_s;
    clr_mask_s   = ({{(DEPTH-1){1'b0}}, bru_ok_s} << bru_free_id)
                 | ({{(DEPTH-1){1'b0}}, commit_ok_s} << commit_free_id);
    in_use_nxt_s = (in_use_r | set_mask_s) & ~clr_mask_s;
  end

  // In-use bitmap; flush and reset both mark every ID free.
  always_ff @(posedge clk) begin
    if (!rst || flush_s) begin
      in_use_r <= MASK_ZERO;
    end else begin
      in_use_r <= in_use_nxt_s;
    end
  end

  // Sticky double-free flag; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  free_list_fifo #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_free_list_fifo (
    .clk    (clk),
    .rst    (rst),
    .init   (flush_s),
    .rd_en  (grant_s),
    .wr0_en (bru_ok_s),
    .wr0_id (bru_free_id),
    .wr1_en (commit_ok_s),
    .wr1_id (commit_free_id),
    .rd_id  (fifo_rd_id_s),
    .count  (fifo_count_s),
    .empty  (fifo_empty_s),
    .full   (fifo_full_s)
  );

  assign alloc_grant     = grant_s;
  assign alloc_id        = fifo_rd_id_s;
  assign free_count      = fifo_count_s;
  assign empty           = fifo_empty_s;
  assign full            = fifo_full_s;
  assign double_free_err = err_r;

endmodule
